// File: rtl/frame_buffer_pipeline_pkg.sv
// Shared constants and types for the tile-based sprite frame buffer pipeline.
// Entity word layout: {ID, orientation, tile}.
package frame_buffer_pipeline_pkg;

  localparam int ENTITY_W   = 14;
  localparam int ID_LSB     = 10;
  localparam int ID_W       = 4;
  localparam int ORIENT_LSB = 8;
  localparam int ORIENT_W   = 2;
  localparam int TILE_LSB   = 0;
  localparam int TILE_W     = 8;

  localparam logic [ID_W-1:0] ID_UNUSED = 4'hF;

  localparam int COORD_W = 10;
  // Bounds carry one extra bit so (col+1)*TILE_PX at the right edge cannot wrap.
  localparam int BOUND_W = 11;

  localparam int DEF_NUM_ENTITIES   = 9;
  localparam int DEF_TILE_PX        = 40;
  localparam int DEF_UPSCALE        = 5;
  localparam int DEF_SCREEN_TILES_H = 16;
  localparam int DEF_SCREEN_TILES_V = 12;
  localparam int DEF_ROM_LATENCY    = 1;

  typedef struct packed {
    logic                valid;
    logic                hit;
    logic                coll;
    logic [ID_W-1:0]     id;
    logic [ORIENT_W-1:0] orient;
    logic [2:0]          line;
    logic [2:0]          px_bit;
  } stage1_t;

  localparam stage1_t STAGE1_RST = '{
    valid:  1'b0,
    hit:    1'b0,
    coll:   1'b0,
    id:     ID_UNUSED,
    orient: '0,
    line:   '0,
    px_bit: '0
  };

endpackage

// File: rtl/frame_buffer_pipeline_entity_hit_detect.sv
// Combinational per-channel tile decode and hit test; also produces the
// sprite line and bit index of the pixel inside the hit tile.
module entity_hit_detect
  import frame_buffer_pipeline_pkg::*;
#(
  parameter int TILE_PX        = DEF_TILE_PX,
  parameter int UPSCALE        = DEF_UPSCALE,
  parameter int SCREEN_TILES_H = DEF_SCREEN_TILES_H,
  parameter int SCREEN_TILES_V = DEF_SCREEN_TILES_V
) (
  input  logic [ID_W-1:0]    i_id,
  input  logic [TILE_W-1:0]  i_tile,
  input  logic [COORD_W-1:0] i_counter_h,
  input  logic [COORD_W-1:0] i_counter_v,
  output logic               o_hit,
  output logic [2:0]         o_line,
  output logic [2:0]         o_bit
);

  localparam logic [BOUND_W-1:0] TILE_PX_B = BOUND_W'(TILE_PX);
  localparam logic [BOUND_W-1:0] UPSCALE_B = BOUND_W'(UPSCALE);
  localparam logic [BOUND_W-1:0] TILES_H_B = BOUND_W'(SCREEN_TILES_H);
  localparam logic [BOUND_W-1:0] TILES_V_B = BOUND_W'(SCREEN_TILES_V);

  logic [BOUND_W-1:0] w_tile;
  logic [BOUND_W-1:0] w_col;
  logic [BOUND_W-1:0] w_row;
  logic [BOUND_W-1:0] w_x_lo;
  logic [BOUND_W-1:0] w_x_hi;
  logic [BOUND_W-1:0] w_y_lo;
  logic [BOUND_W-1:0] w_y_hi;
  logic [BOUND_W-1:0] w_px;
  logic [BOUND_W-1:0] w_py;
  logic [BOUND_W-1:0] w_dx;
  logic [BOUND_W-1:0] w_dy;
  logic               w_in_x;
  logic               w_in_y;
  logic               w_row_ok;

  always_comb begin
    w_tile   = BOUND_W'(i_tile);
    w_col    = w_tile % TILES_H_B;
    w_row    = w_tile / TILES_H_B;
    w_x_lo   = w_col * TILE_PX_B;
    w_x_hi   = w_x_lo + TILE_PX_B;
    w_y_lo   = w_row * TILE_PX_B;
    w_y_hi   = w_y_lo + TILE_PX_B;
    w_px     = BOUND_W'(i_counter_h);
    w_py     = BOUND_W'(i_counter_v);
    w_in_x   = (w_px >= w_x_lo) && (w_px < w_x_hi);
    w_in_y   = (w_py >= w_y_lo) && (w_py < w_y_hi);
    w_row_ok = (w_row < TILES_V_B);
    o_hit    = (i_id != ID_UNUSED) && w_row_ok && w_in_x && w_in_y;
    // Offsets are meaningless when there is no hit; the consumer ignores them then.
    w_dx     = w_px - w_x_lo;
    w_dy     = w_py - w_y_lo;
    o_bit    = 3'(w_dx / UPSCALE_B);
    o_line   = 3'(w_dy / UPSCALE_B);
  end

endmodule

// File: rtl/frame_buffer_pipeline.sv
// Sprite frame buffer pipeline: shadowed entity table, per-pixel priority hit
// detection, sprite ROM request, and ROM-latency-aligned colour output.
module frame_buffer_pipeline
  import frame_buffer_pipeline_pkg::*;
#(
  parameter int   NUM_ENTITIES   = DEF_NUM_ENTITIES,
  parameter int   TILE_PX        = DEF_TILE_PX,
  parameter int   UPSCALE        = DEF_UPSCALE,
  parameter int   SCREEN_TILES_H = DEF_SCREEN_TILES_H,
  parameter int   SCREEN_TILES_V = DEF_SCREEN_TILES_V,
  parameter int   ROM_LATENCY    = DEF_ROM_LATENCY,
  parameter logic BG_COLOUR      = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_ENTITIES*ENTITY_W-1:0] entities,
  input  logic                             frame_start,
  input  logic                             in_valid,
  input  logic [COORD_W-1:0]               counter_H,
  input  logic [COORD_W-1:0]               counter_V,
  output logic [ID_W-1:0]                  rom_sprite_id,
  output logic [ORIENT_W-1:0]              rom_orientation,
  output logic [2:0]                       rom_line,
  input  logic [7:0]                       rom_data,
  output logic                             colour,
  output logic                             colour_valid,
  output logic                             collision
);

  localparam logic [ENTITY_W-1:0] SHADOW_RST = {ID_UNUSED, (ENTITY_W-ID_W)'(0)};

  logic [ENTITY_W-1:0]     r_shadow [NUM_ENTITIES];
  logic [NUM_ENTITIES-1:0] w_hit;
  logic [2:0]              w_line [NUM_ENTITIES];
  logic [2:0]              w_bit  [NUM_ENTITIES];
  stage1_t                 w_s1;
  stage1_t                 r_s1;
  logic                    r_dly_valid [ROM_LATENCY];
  logic                    r_dly_hit   [ROM_LATENCY];
  logic [2:0]              r_dly_bit   [ROM_LATENCY];
  logic                    r_colour;
  logic                    r_colour_valid;

  // Detection in the frame_start cycle still sees the previous shadow contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_ENTITIES; k++) begin
        r_shadow[k] <= SHADOW_RST;
      end
    end else if (frame_start) begin
      for (int unsigned k = 0; k < NUM_ENTITIES; k++) begin
        r_shadow[k] <= entities[k*ENTITY_W +: ENTITY_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_ENTITIES; g++) begin : g_det
    entity_hit_detect #(
      .TILE_PX        (TILE_PX),
      .UPSCALE        (UPSCALE),
      .SCREEN_TILES_H (SCREEN_TILES_H),
      .SCREEN_TILES_V (SCREEN_TILES_V)
    ) u_det (
      .i_id        (r_shadow[g][ID_LSB +: ID_W]),
      .i_tile      (r_shadow[g][TILE_LSB +: TILE_W]),
      .i_counter_h (counter_H),
      .i_counter_v (counter_V),
      .o_hit       (w_hit[g]),
      .o_line      (w_line[g]),
      .o_bit       (w_bit[g])
    );
  end

  // Lowest-index hit wins; any later hit marks a collision.
  always_comb begin
    w_s1       = STAGE1_RST;
    w_s1.valid = in_valid;
    for (int unsigned k = 0; k < NUM_ENTITIES; k++) begin
      if (w_hit[k]) begin
        if (w_s1.hit) begin
          w_s1.coll = 1'b1;
        end else begin
          w_s1.hit    = 1'b1;
          w_s1.id     = r_shadow[k][ID_LSB +: ID_W];
          w_s1.orient = r_shadow[k][ORIENT_LSB +: ORIENT_W];
          w_s1.line   = w_line[k];
          w_s1.px_bit = w_bit[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= STAGE1_RST;
    end else begin
      r_s1 <= w_s1;
    end
  end

  assign rom_sprite_id   = r_s1.hit ? r_s1.id : ID_UNUSED;
  assign rom_orientation = r_s1.orient;
  assign rom_line        = r_s1.line;
  assign collision       = r_s1.coll;

  // Carry pixel context alongside the outstanding ROM read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < ROM_LATENCY; k++) begin
        r_dly_valid[k] <= 1'b0;
        r_dly_hit[k]   <= 1'b0;
        r_dly_bit[k]   <= '0;
      end
    end else begin
      r_dly_valid[0] <= r_s1.valid;
      r_dly_hit[0]   <= r_s1.hit;
      r_dly_bit[0]   <= r_s1.px_bit;
      for (int unsigned k = 1; k < ROM_LATENCY; k++) begin
        r_dly_valid[k] <= r_dly_valid[k-1];
        r_dly_hit[k]   <= r_dly_hit[k-1];
        r_dly_bit[k]   <= r_dly_bit[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_colour       <= BG_COLOUR;
      r_colour_valid <= 1'b0;
    end else begin
      r_colour_valid <= r_dly_valid[ROM_LATENCY-1];
      if (r_dly_valid[ROM_LATENCY-1] && r_dly_hit[ROM_LATENCY-1]) begin
        r_colour <= rom_data[r_dly_bit[ROM_LATENCY-1]];
      end else begin
        r_colour <= BG_COLOUR;
      end
    end
  end

  assign colour       = r_colour;
  assign colour_valid = r_colour_valid;

endmodule

// File: tb/tb_frame_buffer_pipeline.sv
// Directed, table-driven bench for frame_buffer_pipeline with a 1-cycle sprite ROM model.
module tb_frame_buffer_pipeline;

  localparam int NE = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic [NE*14-1:0] entities;
  logic            frame_start;
  logic            in_valid;
  logic [9:0]      counter_H;
  logic [9:0]      counter_V;
  logic [3:0]      rom_sprite_id;
  logic [1:0]      rom_orientation;
  logic [2:0]      rom_line;
  logic [7:0]      rom_data;
  logic            colour;
  logic            colour_valid;
  logic            collision;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cfg;
    int h;
    int v;
    bit hit;
    int id;
    int orient;
    int line;
    int pbit;
    bit coll;
  } vec_t;

  vec_t vecs[$];

  frame_buffer_pipeline #(
    .NUM_ENTITIES (NE),
    .ROM_LATENCY  (1),
    .BG_COLOUR    (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .entities        (entities),
    .frame_start     (frame_start),
    .in_valid        (in_valid),
    .counter_H       (counter_H),
    .counter_V       (counter_V),
    .rom_sprite_id   (rom_sprite_id),
    .rom_orientation (rom_orientation),
    .rom_line        (rom_line),
    .rom_data        (rom_data),
    .colour          (colour),
    .colour_valid    (colour_valid),
    .collision       (collision)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(logic [3:0] id, logic [1:0] o, logic [2:0] l);
    logic [8:0]  v;
    logic [17:0] p;
    v = {id, o, l};
    p = 18'(v) * 18'd151;
    return p[7:0] ^ 8'(v >> 3);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_sprite_id, rom_orientation, rom_line);

  function automatic logic [13:0] mk(int id, int o, int tile);
    return {4'(id), 2'(o), 8'(tile)};
  endfunction

  function automatic logic [NE*14-1:0] cfg_bus(int c);
    logic [NE*14-1:0] b;
    for (int k = 0; k < NE; k++) b[14*k +: 14] = mk(15, 0, 0);
    case (c)
      0: b[0 +: 14] = mk(2, 0, 17);
      1: begin
        b[0 +: 14]    = mk(2, 0, 17);
        b[14*3 +: 14] = mk(7, 3, 17);
        b[14*5 +: 14] = mk(9, 2, 0);
      end
      2: begin
        b[14*1 +: 14] = mk(4, 1, 200);
        b[14*2 +: 14] = mk(5, 1, 191);
      end
      4: b[0 +: 14] = mk(2, 0, 0);
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic exp_colour(vec_t x);
    logic [7:0] d;
    if (!x.hit) return 1'b1;
    d = rom_fn(4'(x.id), 2'(x.orient), 3'(x.line));
    return d[x.pbit];
  endfunction

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(int cfg, int h, int v, bit hit, int id, int o, int line, int pbit, bit coll);
    vec_t x;
    x = '{cfg: cfg, h: h, v: v, hit: hit, id: id, orient: o, line: line, pbit: pbit, coll: coll};
    vecs.push_back(x);
  endtask

  task automatic drive_pixel(int h, int v);
    in_valid  = 1'b1;
    counter_H = 10'(h);
    counter_V = 10'(v);
  endtask

  task automatic drive_idle();
    in_valid  = 1'b0;
    counter_H = '0;
    counter_V = '0;
  endtask

  task automatic load_cfg(int c);
    @(posedge clk); #1;
    entities    = cfg_bus(c);
    frame_start = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic check_request(int i);
    vec_t x;
    x = vecs[i];
    if (x.hit) begin
      check($sformatf("v%0d rom_sprite_id", i), rom_sprite_id, x.id);
      check($sformatf("v%0d rom_orientation", i), rom_orientation, x.orient);
      check($sformatf("v%0d rom_line", i), rom_line, x.line);
    end else begin
      check($sformatf("v%0d rom_sprite_id(nohit)", i), rom_sprite_id, 15);
    end
    check($sformatf("v%0d collision", i), collision, x.coll);
  endtask

  // Back-to-back pixels: request checked 1 cycle after, colour 3 cycles after.
  task automatic run_group(int lo, int hi);
    int n;
    n = hi - lo + 1;
    for (int t = 0; t <= n + 3; t++) begin
      @(posedge clk); #1;
      if (t >= 1 && t <= n) check_request(lo + t - 1);
      if (t >= 3 && t <= n + 2) begin
        check($sformatf("v%0d colour_valid", lo + t - 3), colour_valid, 1);
        check($sformatf("v%0d colour", lo + t - 3), colour, exp_colour(vecs[lo + t - 3]));
      end
      if (t == n + 3) begin
        check($sformatf("grp%0d idle colour_valid", lo), colour_valid, 0);
        check($sformatf("grp%0d idle colour", lo), colour, 1);
      end
      if (t < n) drive_pixel(vecs[lo + t].h, vecs[lo + t].v);
      else drive_idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    int j;

    // tile 17 -> col 1, row 1 (x/y 40..79); tile 0 -> origin; tile 191 -> col 15, row 11; tile 200 -> row 12
    add_vec(0,  45,  50, 1, 2, 0, 2, 1, 0);
    add_vec(0,  80,  50, 0, 0, 0, 0, 0, 0);
    add_vec(0,  45,  80, 0, 0, 0, 0, 0, 0);
    add_vec(0,  40,  40, 1, 2, 0, 0, 0, 0);
    add_vec(0,  79,  79, 1, 2, 0, 7, 7, 0);
    add_vec(0,  39,  50, 0, 0, 0, 0, 0, 0);
    add_vec(0,  79,  40, 1, 2, 0, 0, 7, 0);
    add_vec(1,  40,  40, 1, 2, 0, 0, 0, 1);
    add_vec(1,  60,  55, 1, 2, 0, 3, 4, 1);
    add_vec(1,   0,   0, 1, 9, 2, 0, 0, 0);
    add_vec(1,  39,  39, 1, 9, 2, 7, 7, 0);
    add_vec(1,  40,   0, 0, 0, 0, 0, 0, 0);
    add_vec(2, 325, 485, 0, 0, 0, 0, 0, 0);
    add_vec(2, 639, 479, 1, 5, 1, 7, 7, 0);
    add_vec(2, 600, 440, 1, 5, 1, 0, 0, 0);
    add_vec(2, 599, 440, 0, 0, 0, 0, 0, 0);
    add_vec(3,   0,   0, 0, 0, 0, 0, 0, 0);
    add_vec(3,  45,  50, 0, 0, 0, 0, 0, 0);
    add_vec(3, 639, 479, 0, 0, 0, 0, 0, 0);

    reset       = 1'b0;
    entities    = cfg_bus(0);
    frame_start = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset colour", colour, 1);
    check("reset colour_valid", colour_valid, 0);
    check("reset collision", collision, 0);
    check("reset rom_sprite_id", rom_sprite_id, 15);
    reset = 1'b1;

    i = 0;
    while (i < vecs.size()) begin
      j = i;
      while (j + 1 < vecs.size() && vecs[j + 1].cfg == vecs[i].cfg) j++;
      load_cfg(vecs[i].cfg);
      run_group(i, j);
      i = j + 1;
    end

    // Shadow update only takes effect on frame_start, and not within that cycle.
    load_cfg(0);
    entities = cfg_bus(4);
    drive_pixel(45, 50);
    @(posedge clk); #1;
    check("nofs rom_sprite_id", rom_sprite_id, 2);
    check("nofs rom_line", rom_line, 2);
    frame_start = 1'b1;
    @(posedge clk); #1;
    check("fs cycle rom_sprite_id", rom_sprite_id, 2);
    frame_start = 1'b0;
    @(posedge clk); #1;
    check("after fs old pos rom_sprite_id", rom_sprite_id, 15);
    drive_pixel(5, 10);
    @(posedge clk); #1;
    check("after fs new pos rom_sprite_id", rom_sprite_id, 2);
    check("after fs new pos rom_line", rom_line, 2);
    drive_idle();
    repeat (4) @(posedge clk);

    // One-cycle reset in the middle of a valid pixel stream.
    load_cfg(0);
    drive_pixel(45, 50);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset colour_valid", colour_valid, 1);
    check("pre-reset colour", colour, exp_colour(vecs[0]));
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst colour_valid", colour_valid, 0);
    check("midrst colour", colour, 1);
    check("midrst rom_sprite_id", rom_sprite_id, 15);
    check("midrst collision", collision, 0);
    @(posedge clk); #1;
    check("rel+1 rom_sprite_id (shadow unused)", rom_sprite_id, 15);
    check("rel+1 colour_valid", colour_valid, 0);
    @(posedge clk); #1;
    check("rel+2 colour_valid", colour_valid, 0);
    @(posedge clk); #1;
    check("rel+3 colour_valid", colour_valid, 1);
    check("rel+3 colour", colour, 1);
    drive_idle();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
